// File: rtl/instr_fetch_prims_pkg.sv
// rtl/instr_fetch_prims_pkg.sv - shared widths, PC type and ROM image for the fetch slice
package instr_fetch_prims_pkg;

  localparam int PC_W    = 30;
  localparam int INSTR_W = 32;
  localparam int IMM_W   = 16;
  localparam int JADDR_W = 26;

  typedef logic [PC_W-1:0] word_pc_t;

  // Program image byte at a given ROM byte index; every byte is defined so
  // the fetch path never produces X.
  function automatic logic [7:0] rom_image_byte(input int unsigned idx);
    return 8'((idx * 7 + 3) & 32'hFF);
  endfunction

endpackage

// File: rtl/instr_fetch_prims_prims.sv
// rtl/instr_fetch_prims_prims.sv - 30-bit 2:1 mux and 16->30 sign extender
module mux2_30
  import instr_fetch_prims_pkg::*;
(
  input  word_pc_t a,
  input  word_pc_t b,
  input  logic     sel,
  output word_pc_t y
);

  assign y = sel ? a : b;

endmodule

module signext16_30
  import instr_fetch_prims_pkg::*;
(
  input  logic [IMM_W-1:0] x,
  output word_pc_t         y
);

  assign y = {{(PC_W-IMM_W){x[IMM_W-1]}}, x};

endmodule

// File: rtl/instr_fetch_prims_rom.sv
// rtl/instr_fetch_prims_rom.sv - byte-organised big-endian instruction ROM, combinational read
module rom
  import instr_fetch_prims_pkg::*;
#(
  parameter int ROM_BYTES = 256,
  parameter int ROM_AW    = 8
) (
  input  logic [ROM_AW-1:0]  addr,
  output logic [INSTR_W-1:0] data
);

  // Byte storage; the image is constant, so this is a pure lookup table.
  if (1) begin : storage
    logic [7:0] bytes [ROM_BYTES];
    for (genvar i = 0; i < ROM_BYTES; i++) begin : g_img
      assign bytes[i] = rom_image_byte(i);
    end
  end

  // Byte lanes wrap modulo ROM_BYTES through the natural overflow of ROM_AW.
  logic [ROM_AW-1:0] a1, a2, a3;
  assign a1 = addr + ROM_AW'(1);
  assign a2 = addr + ROM_AW'(2);
  assign a3 = addr + ROM_AW'(3);

  assign data = {storage.bytes[addr], storage.bytes[a1],
                 storage.bytes[a2],   storage.bytes[a3]};

endmodule

// File: rtl/instr_fetch_prims.sv
// rtl/instr_fetch_prims.sv - word PC register, next-PC selection and instruction ROM
module instr_fetch_prims
  import instr_fetch_prims_pkg::*;
#(
  parameter int       ROM_BYTES = 256,
  parameter int       ROM_AW    = 8,
  parameter word_pc_t PC_RESET  = 30'h3FFF_FFFF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IMM_W-1:0]    imm16,
  input  logic [JADDR_W-1:0]  addr26,
  input  logic                is_branch,
  input  logic                is_jump,
  output logic [INSTR_W-1:0]  instruction,
  output word_pc_t            pc
);

  word_pc_t pc_seq, imm_ext, pc_branch, pc_jump, pc_sb, pc_new;
  logic [ROM_AW-1:0] rom_addr;

  assign pc_seq = pc + 30'd1;

  signext16_30 u_sext (
    .x (imm16),
    .y (imm_ext)
  );

  // Branch offset is applied to the current PC, not PC+1.
  assign pc_branch = pc + imm_ext;
  assign pc_jump   = {pc[PC_W-1:JADDR_W], addr26};

  mux2_30 bmux (
    .a   (pc_branch),
    .b   (pc_seq),
    .sel (is_branch),
    .y   (pc_sb)
  );

  // Jump wins over branch when both are requested.
  mux2_30 jmux (
    .a   (pc_jump),
    .b   (pc_sb),
    .sel (is_jump),
    .y   (pc_new)
  );

  // PC advances on the falling edge; reset forces it to PC_RESET immediately.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) pc <= PC_RESET;
    else     pc <= pc_new;
  end

  // Only the low PC bits reach the ROM; higher bits alias.
  assign rom_addr = {pc[ROM_AW-3:0], 2'b00};

  rom #(
    .ROM_BYTES (ROM_BYTES),
    .ROM_AW    (ROM_AW)
  ) u_rom (
    .addr (rom_addr),
    .data (instruction)
  );

endmodule

// File: tb/tb_instr_fetch_prims.sv
// tb/tb_instr_fetch_prims.sv - directed self-checking bench for instr_fetch_prims
module tb_instr_fetch_prims;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] imm16;
  logic [25:0] addr26;
  logic        is_branch;
  logic        is_jump;
  logic [31:0] instruction;
  logic [29:0] pc;

  int tests = 0;
  int fails = 0;

  instr_fetch_prims dut (
    .clk         (clk),
    .rst         (rst),
    .imm16       (imm16),
    .addr26      (addr26),
    .is_branch   (is_branch),
    .is_jump     (is_jump),
    .instruction (instruction),
    .pc          (pc)
  );

  always #5 clk = ~clk;

  // Expected image: byte n of the program is (n*7+3) mod 256.
  function automatic logic [7:0] img(input int n);
    int m;
    m = n % 256;
    return 8'((m * 7 + 3) % 256);
  endfunction

  function automatic logic [31:0] word_at(input int byte_addr);
    return {img(byte_addr), img(byte_addr + 1), img(byte_addr + 2), img(byte_addr + 3)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One PC update: cross a falling edge, then sample just after the rising edge.
  task automatic step();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; imm16 = 16'h0; addr26 = 26'h0; is_branch = 1'b0; is_jump = 1'b0;
    #3;
    chk("reset_pc",   {2'b0, pc}, 32'h3FFF_FFFF);
    chk("reset_inst", instruction, word_at(252));

    @(posedge clk); #1;
    rst = 1'b0;
    step();
    chk("first_pc",   {2'b0, pc}, 32'h0);
    chk("first_inst", instruction, word_at(0));

    repeat (4) step();
    chk("seq_pc",   {2'b0, pc}, 32'd4);
    chk("seq_inst", instruction, word_at(16));

    step();
    chk("seq5_pc", {2'b0, pc}, 32'd5);

    is_branch = 1'b1; imm16 = 16'hFFFE;
    step();
    chk("br_back_pc", {2'b0, pc}, 32'd3);

    is_branch = 1'b0;
    repeat (2) step();
    is_branch = 1'b1; imm16 = 16'h0004;
    step();
    chk("br_fwd_pc",   {2'b0, pc}, 32'd9);
    chk("br_fwd_inst", instruction, word_at(36));

    imm16 = 16'd54;
    step();
    chk("wrap63_pc",   {2'b0, pc}, 32'd63);
    chk("wrap63_inst", instruction, word_at(252));

    is_branch = 1'b0;
    step();
    chk("alias64_pc",   {2'b0, pc}, 32'd64);
    chk("alias64_inst", instruction, word_at(0));

    is_branch = 1'b1; imm16 = 16'hFFBF;
    step();
    chk("br_under_pc", {2'b0, pc}, 32'h3FFF_FFFF);

    is_branch = 1'b0;
    repeat (2) step();
    chk("pc_wrap_seq", {2'b0, pc}, 32'd1);

    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_pc", {2'b0, pc}, 32'h3FFF_FFFF);
    is_jump = 1'b1; is_branch = 1'b1; addr26 = 26'h000_0020; imm16 = 16'h0004;
    repeat (2) step();
    chk("rst_hold_pc", {2'b0, pc}, 32'h3FFF_FFFF);

    rst = 1'b0;
    step();
    chk("jump_prio_pc",   {2'b0, pc}, 32'h3C00_0020);
    chk("jump_prio_inst", instruction, word_at(128));

    is_branch = 1'b0; addr26 = 26'h000_0005;
    step();
    chk("jump_only_pc",   {2'b0, pc}, 32'h3C00_0005);
    chk("jump_only_inst", instruction, word_at(20));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
